mapper_ram_responder: RTL and testbench

// - Memory-side responder for slot mappers: accepts the translated ROM/RAM address and chip select from a mapper's

---
 rtl/mapper_ram_responder.sv | 202 ++++++++++++++++++++
 tb/tb_mapper_ram_responder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mapper_ram_responder.sv
// mapper_ram_responder
// Memory-side responder for slot mappers. Takes the translated address and
// chip select from the mapper output mux, runs exactly one SDRAM transaction
// per CPU access and stalls the Z80 through cpu_wait until the data is back.
// A transaction that never sees an ack is forced to complete after TIMEOUT
// cycles and leaves a sticky timeout_err behind.
//
// Optional feature: define MAPPER_RESP_CACHE_EN to add a one-entry read cache
// (tag/data/valid). Without the macro every access goes to SDRAM and no cache
// state is built.

module mapper_ram_responder #(
  parameter int ADDR_W  = 27,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_cs,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [7:0]        req_wdata,
  output logic              cpu_wait,
  output logic [7:0]        cpu_rdata,
  output logic              rdata_valid,
  output logic              timeout_err,
  output logic              sdram_req,
  output logic              sdram_we,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [7:0]        sdram_din,
  input  logic              sdram_ack,
  input  logic [7:0]        sdram_dout
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  // Terminal count of the ack watchdog and its increment.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  // FSM and datapath registers.
  state_t            r_state;
  logic              r_act_d;
  logic [TO_W-1:0]   r_to_cnt;
  logic [7:0]        r_cpu_rdata;
  logic              r_rdata_valid;
  logic              r_timeout_err;
  logic              r_sdram_req;
  logic              r_sdram_we;
  logic [ADDR_W-1:0] r_sdram_addr;
  logic [7:0]        r_sdram_din;

  // Decoded access conditions.
  logic              w_act;
  logic              w_start;
  logic              w_busy;
  logic              w_to_last;
  logic              w_hit;
  logic [7:0]        w_hit_data;

  // An access exists only while the mapper selects RAM and the CPU strobes.
  assign w_act     = req_cs & (req_rd | req_wr);
  // Only a rising act edge seen in IDLE opens a transaction, so a strobe held
  // past completion cannot start a second one.
  assign w_start   = w_act & ~r_act_d & (r_state == ST_IDLE);
  assign w_busy    = (r_state == ST_REQ) | (r_state == ST_WAIT_ACK);
  assign w_to_last = (r_to_cnt == TO_LAST);

`ifdef MAPPER_RESP_CACHE_EN
  // One-entry read cache.
  logic [ADDR_W-1:0] r_tag;
  logic [7:0]        r_cache_data;
  logic              r_cache_valid;
  logic              w_tag_match;
  logic              w_fill;
  logic              w_wr_update;

  assign w_tag_match = r_cache_valid & (req_addr == r_tag);
  // Both strobes high counts as a write, so it can never hit.
  assign w_hit       = w_start & ~req_wr & w_tag_match;
  assign w_hit_data  = r_cache_data;
  // Fill only on a real read ack; a timed-out read leaves the entry alone.
  assign w_fill      = (r_state == ST_WAIT_ACK) & sdram_ack & ~r_sdram_we;
  // Write-through keeps the cached byte coherent with SDRAM.
  assign w_wr_update = w_start & req_wr & w_tag_match;

  // Cache entry maintenance: miss fill and write-through update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag         <= {ADDR_W{1'b0}};
      r_cache_data  <= 8'h00;
      r_cache_valid <= 1'b0;
    end else if (w_fill) begin
      r_tag         <= r_sdram_addr;
      r_cache_data  <= sdram_dout;
      r_cache_valid <= 1'b1;
    end else if (w_wr_update) begin
      r_cache_data  <= req_wdata;
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = 8'hFF;
`endif

  // The CPU is stalled from the very first access cycle (combinationally)
  // until the transaction has left WAIT_ACK; cache hits never stall.
  assign cpu_wait = (w_start & ~w_hit) | w_busy;

  // Edge detector for the CPU access strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_act_d <= 1'b0;
    end else begin
      r_act_d <= w_act;
    end
  end

  // Transaction FSM with registered SDRAM and CPU-side outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_to_cnt      <= {TO_W{1'b0}};
      r_cpu_rdata   <= 8'hFF;
      r_rdata_valid <= 1'b0;
      r_timeout_err <= 1'b0;
      r_sdram_req   <= 1'b0;
      r_sdram_we    <= 1'b0;
      r_sdram_addr  <= {ADDR_W{1'b0}};
      r_sdram_din   <= 8'h00;
    end else begin
      // Single-cycle strobes default low every cycle.
      r_rdata_valid <= 1'b0;
      r_sdram_req   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            // Cached read: answer next cycle without touching SDRAM.
            r_cpu_rdata   <= w_hit_data;
            r_rdata_valid <= 1'b1;
            r_state       <= ST_DONE;
          end else if (w_start) begin
            // Latch the request; the SDRAM side sees it stable until done.
            r_sdram_addr  <= req_addr;
            r_sdram_we    <= req_wr;
            r_sdram_din   <= req_wdata;
            r_sdram_req   <= 1'b1;
            r_state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          // sdram_req is high for exactly this cycle; arm the watchdog.
          r_to_cnt <= {TO_W{1'b0}};
          r_state  <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          r_to_cnt <= r_to_cnt + TO_ONE;
          if (sdram_ack) begin
            // A real ack always wins over the terminal count.
            if (!r_sdram_we) begin
              r_cpu_rdata   <= sdram_dout;
              r_rdata_valid <= 1'b1;
            end
            r_state <= ST_DONE;
          end else if (w_to_last) begin
            // Forced completion: reads return the open-bus value.
            if (!r_sdram_we) begin
              r_cpu_rdata   <= 8'hFF;
              r_rdata_valid <= 1'b1;
            end
            r_timeout_err <= 1'b1;
            r_state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Wait for the CPU to release the strobe before re-arming.
          if (!w_act) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu_rdata   = r_cpu_rdata;
  assign rdata_valid = r_rdata_valid;
  assign timeout_err = r_timeout_err;
  assign sdram_req   = r_sdram_req;
  assign sdram_we    = r_sdram_we;
  assign sdram_addr  = r_sdram_addr;
  assign sdram_din   = r_sdram_din;

endmodule

// File: tb/tb_mapper_ram_responder.sv
// Testbench for mapper_ram_responder (built with TIMEOUT=4).
// Table of CPU accesses plus hand sequences for cache, held strobe, CPU abort,
// chip-select gating and reset in the middle of a transaction.

module tb_mapper_ram_responder;

  localparam int AW = 27;
  localparam int TO = 4;
`ifdef MAPPER_RESP_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  localparam int HIT_WAIT = CACHE ? 0 : 4;
  localparam int HIT_REQ  = CACHE ? 0 : 1;

  logic          clk;
  logic          reset_n;
  logic [AW-1:0] req_addr;
  logic          req_cs;
  logic          req_rd;
  logic          req_wr;
  logic [7:0]    req_wdata;
  logic          cpu_wait;
  logic [7:0]    cpu_rdata;
  logic          rdata_valid;
  logic          timeout_err;
  logic          sdram_req;
  logic          sdram_we;
  logic [AW-1:0] sdram_addr;
  logic [7:0]    sdram_din;
  logic          sdram_ack;
  logic [7:0]    sdram_dout;

  mapper_ram_responder #(.ADDR_W(AW), .TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_addr(req_addr), .req_cs(req_cs), .req_rd(req_rd), .req_wr(req_wr),
    .req_wdata(req_wdata),
    .cpu_wait(cpu_wait), .cpu_rdata(cpu_rdata), .rdata_valid(rdata_valid),
    .timeout_err(timeout_err),
    .sdram_req(sdram_req), .sdram_we(sdram_we), .sdram_addr(sdram_addr),
    .sdram_din(sdram_din), .sdram_ack(sdram_ack), .sdram_dout(sdram_dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [26:0] addr;
    logic [7:0] wdata;
    int         ack_dly;    // cycles after sdram_req; -1 = never
    logic [7:0] ack_data;
    int         exp_wait;   // cycles cpu_wait is high
    logic [7:0] exp_rdata;  // cpu_rdata after completion
    logic       exp_to;     // this access times out
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] exp_q[$];
  int         n_cmp;
  int         n_bad;
  int         req_total;
  logic       mdl_to_err;
  int         snap;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  // Sample point of every cycle; also scoreboards rdata_valid pulses.
  task automatic sample();
    logic [7:0] e;
    @(negedge clk);
    if (reset_n) begin
      if (sdram_req) req_total++;
      if (rdata_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rdata_valid", {31'd0, rdata_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rdata_at_valid", {24'd0, cpu_rdata}, {24'd0, e});
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    sample();
    step();
  endtask

  // One CPU access from first act cycle through release of the strobe.
  task automatic run_txn(input string nm, input logic rd, input logic wr,
                         input logic [26:0] addr, input logic [7:0] wdata,
                         input int ack_dly, input logic [7:0] ack_data,
                         input int exp_wait, input int exp_req,
                         input logic [7:0] exp_rdata, input logic exp_to,
                         input int hold, input int idle);
    int wait_cnt;
    int req_cyc;
    int req_cnt;
    bit done;
    wait_cnt = 0;
    req_cyc  = -1;
    req_cnt  = 0;
    done     = 1'b0;
    req_cs = 1'b1; req_rd = rd; req_wr = wr; req_addr = addr; req_wdata = wdata;
    if (!wr) exp_q.push_back(exp_rdata);
    if (exp_to) mdl_to_err = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      if (req_cyc >= 0 && ack_dly >= 0 && c == req_cyc + ack_dly) begin
        sdram_ack = 1'b1; sdram_dout = ack_data;
      end else begin
        sdram_ack = 1'b0; sdram_dout = 8'h00;
      end
      sample();
      if (sdram_req) begin
        req_cnt++;
        if (req_cyc < 0) req_cyc = c;
        if (wr) chk({nm, ".sdram_din"}, {24'd0, sdram_din}, {24'd0, wdata});
      end
      if (cpu_wait) begin
        wait_cnt++;
        if (c > 0) begin
          chk({nm, ".sdram_addr"}, {5'd0, sdram_addr}, {5'd0, addr});
          chk({nm, ".sdram_we"}, {31'd0, sdram_we}, {31'd0, wr});
        end
        step();
      end else begin
        done = 1'b1;
      end
    end
    chk({nm, ".completed"}, {31'd0, done}, 32'd1);
    chk({nm, ".wait_cycles"}, wait_cnt, exp_wait);
    chk({nm, ".sdram_reqs"}, req_cnt, exp_req);
    chk({nm, ".timeout_err"}, {31'd0, timeout_err}, {31'd0, mdl_to_err});
    sdram_ack = 1'b0;
    step();
    repeat (hold) cyc();
    req_cs = 1'b0; req_rd = 1'b0; req_wr = 1'b0; req_addr = {AW{1'b1}}; req_wdata = 8'h00;
    repeat (idle) cyc();
    chk({nm, ".cpu_rdata"}, {24'd0, cpu_rdata}, {24'd0, exp_rdata});
    chk({nm, ".valid_q_empty"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    clk = 1'b0; reset_n = 1'b0;
    req_cs = 1'b0; req_rd = 1'b0; req_wr = 1'b0; req_addr = {AW{1'b1}}; req_wdata = 8'h00;
    sdram_ack = 1'b0; sdram_dout = 8'h00;
    n_cmp = 0; n_bad = 0; req_total = 0; mdl_to_err = 1'b0;

    //         rd    wr    addr          wdata  dly ackdat wait rdata  to
    vecs[0] = '{1'b1, 1'b0, 27'h0004123, 8'h00,  3, 8'h5A, 5, 8'h5A, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 27'h0010000, 8'hC3,  2, 8'h00, 4, 8'h5A, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 27'h1234567, 8'h00,  1, 8'hA5, 3, 8'hA5, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 27'h7FFFFFE, 8'h00,  4, 8'h96, 6, 8'h96, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 27'h0000040, 8'h3E,  2, 8'h00, 4, 8'h96, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 27'h0000100, 8'h00, -1, 8'h00, 6, 8'hFF, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 27'h0000200, 8'h00,  2, 8'h3C, 4, 8'h3C, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 27'h0000300, 8'hE7, -1, 8'h00, 6, 8'h3C, 1'b1};

    // Reset values.
    sample();
    chk("rst.cpu_rdata", {24'd0, cpu_rdata}, 32'h0000_00FF);
    chk("rst.rdata_valid", {31'd0, rdata_valid}, 32'd0);
    chk("rst.timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("rst.sdram_req", {31'd0, sdram_req}, 32'd0);
    chk("rst.sdram_we", {31'd0, sdram_we}, 32'd0);
    chk("rst.sdram_addr", {5'd0, sdram_addr}, 32'd0);
    chk("rst.sdram_din", {24'd0, sdram_din}, 32'd0);
    chk("rst.cpu_wait", {31'd0, cpu_wait}, 32'd0);
    step();
    cyc();
    reset_n = 1'b1;
    cyc();

    // Table-driven accesses.
    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
              vecs[i].ack_dly, vecs[i].ack_data, vecs[i].exp_wait, 1,
              vecs[i].exp_rdata, vecs[i].exp_to, 0, 2);
    end

    // Repeated read of one address, write-through, and read again.
    run_txn("cache_fill", 1'b1, 1'b0, 27'h0002000, 8'h00, 2, 8'h11, 4, 1, 8'h11, 1'b0, 0, 2);
    snap = req_total;
    run_txn("cache_hit", 1'b1, 1'b0, 27'h0002000, 8'h00, 2, 8'h11, HIT_WAIT, HIT_REQ, 8'h11, 1'b0, 0, 2);
    chk("cache_hit.req_total", req_total - snap, HIT_REQ);
    run_txn("cache_wr", 1'b0, 1'b1, 27'h0002000, 8'h77, 2, 8'h00, 4, 1, 8'h11, 1'b0, 0, 2);
    run_txn("cache_hit2", 1'b1, 1'b0, 27'h0002000, 8'h00, 2, 8'h77, HIT_WAIT, HIT_REQ, 8'h77, 1'b0, 0, 2);

    // Strobe held 10 cycles past completion, then a 1-cycle gap.
    snap = req_total;
    run_txn("hold1", 1'b1, 1'b0, 27'h0006000, 8'h00, 2, 8'h41, 4, 1, 8'h41, 1'b0, 10, 1);
    chk("hold1.req_total", req_total - snap, 32'd1);
    run_txn("hold2", 1'b1, 1'b0, 27'h0006001, 8'h00, 2, 8'h42, 4, 1, 8'h42, 1'b0, 0, 2);
    chk("hold2.req_total", req_total - snap, 32'd2);

    // CPU drops the strobe while waiting for the ack.
    req_cs = 1'b1; req_rd = 1'b1; req_addr = 27'h0003333;
    exp_q.push_back(8'h9E);
    cyc();
    sample();
    chk("abort.sdram_req", {31'd0, sdram_req}, 32'd1);
    step();
    cyc();
    req_cs = 1'b0; req_rd = 1'b0; req_addr = {AW{1'b1}};
    sample();
    chk("abort.wait_after_drop", {31'd0, cpu_wait}, 32'd1);
    step();
    sdram_ack = 1'b1; sdram_dout = 8'h9E;
    sample();
    chk("abort.wait_at_ack", {31'd0, cpu_wait}, 32'd1);
    step();
    sdram_ack = 1'b0; sdram_dout = 8'h00;
    sample();
    chk("abort.wait_done", {31'd0, cpu_wait}, 32'd0);
    chk("abort.cpu_rdata", {24'd0, cpu_rdata}, 32'h0000_009E);
    step();
    chk("abort.valid_q_empty", exp_q.size(), 32'd0);
    run_txn("post_abort", 1'b1, 1'b0, 27'h0003334, 8'h00, 2, 8'h5C, 4, 1, 8'h5C, 1'b0, 0, 2);

    // Strobes without chip select are not accesses.
    snap = req_total;
    req_cs = 1'b0; req_rd = 1'b1; req_addr = 27'h0000777;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("cs_low.cpu_wait", {31'd0, cpu_wait}, 32'd0);
      step();
    end
    req_rd = 1'b0; req_addr = {AW{1'b1}};
    chk("cs_low.req_total", req_total - snap, 32'd0);

    // Reset while in WAIT_ACK, then a stray ack.
    req_cs = 1'b1; req_rd = 1'b1; req_addr = 27'h0005555;
    cyc(); cyc(); cyc();
    sample();
    chk("midrst.wait_before", {31'd0, cpu_wait}, 32'd1);
    #2;
    req_cs = 1'b0; req_rd = 1'b0; req_addr = {AW{1'b1}};
    reset_n = 1'b0;
    mdl_to_err = 1'b0;
    #1;
    chk("midrst.cpu_wait", {31'd0, cpu_wait}, 32'd0);
    chk("midrst.sdram_req", {31'd0, sdram_req}, 32'd0);
    chk("midrst.cpu_rdata", {24'd0, cpu_rdata}, 32'h0000_00FF);
    chk("midrst.timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("midrst.sdram_addr", {5'd0, sdram_addr}, 32'd0);
    step();
    cyc();
    reset_n = 1'b1;
    sdram_ack = 1'b1; sdram_dout = 8'hAA;
    cyc();
    sdram_ack = 1'b0; sdram_dout = 8'h00;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("stray_ack.cpu_wait", {31'd0, cpu_wait}, 32'd0);
      chk("stray_ack.sdram_req", {31'd0, sdram_req}, 32'd0);
      chk("stray_ack.rdata_valid", {31'd0, rdata_valid}, 32'd0);
      chk("stray_ack.cpu_rdata", {24'd0, cpu_rdata}, 32'h0000_00FF);
      step();
    end
    run_txn("post_rst", 1'b1, 1'b0, 27'h0005555, 8'h00, 2, 8'h6B, 4, 1, 8'h6B, 1'b0, 0, 2);

    chk("final.valid_q_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
